avalon_addr_decoder: RTL and testbench
======================================

// Module: avalon_addr_decoder
// PURPOSE
//  One Avalon-MM master port fanned out to NUM_SLAVES slave ports, selected by an address field.
//  Provides the master-to-many-slaves direction of the interconnect.
//  Locks the slave selection for the whole of a multi-beat burst.
//  Routes read data back through a registered select.
//  Terminates unmapped accesses locally and records them in error status.
// PARAMETERS
//  NUM_SLAVES  2   number of slave ports, 1..15
//  SEL_MSB     29  MSB of the slave-index field in the word address
//  SEL_LSB     28  LSB of the slave-index field; field width = SEL_MSB-SEL_LSB+1
// PORTS
//  i_Clk               in   1              clock
//  i_Reset             in   1              synchronous reset, active-high
//  i_AVIn_Addr         in   30             master word address
//  i_AVIn_ByteEn       in   4              master byte enables
//  i_AVIn_Read         in   1              master read request
//  o_AVIn_ReadData     out  32             read data to master
//  i_AVIn_Write        in   1              master write request
//  i_AVIn_WriteData    in   32             master write data
//  o_AVIn_WaitRequest  out  1              stall to master
//  i_AVIn_BurstCount   in   8              beats in burst, 0 treated as 1
//  o_AVOut_Addr        out  30*NUM_SLAVES  address broadcast to every slave
//  o_AVOut_ByteEn      out  4*NUM_SLAVES   byte enables broadcast to every slave
//  o_AVOut_Read        out  NUM_SLAVES     per-slave read, one-hot or zero
//  i_AVOut_ReadData    in   32*NUM_SLAVES  per-slave read data
//  o_AVOut_Write       out  NUM_SLAVES     per-slave write, one-hot or zero
//  o_AVOut_WriteData   out  32*NUM_SLAVES  write data broadcast to every slave
//  i_AVOut_WaitRequest in   NUM_SLAVES     per-slave stall
//  o_AVOut_BurstCount  out  8*NUM_SLAVES   burst count broadcast to every slave
//  o_ErrCount          out  16             saturating count of unmapped beats
//  o_ErrAddr           out  30             address of the most recent unmapped first beat
// BEHAVIOUR
//  Decode
//   - idx = Addr[SEL_MSB:SEL_LSB]; idx >= NUM_SLAVES means unmapped.
//   - Target: IDLE uses the decoded idx; BURST uses the locked r_Sel and ignores Addr.
//  Request path
//   - Addr, ByteEn, WriteData and BurstCount are passed to every slave slice unchanged (combinational).
//   - Read/Write are forwarded combinationally to the target slave only; all other bits are 0.
//   - Unmapped target: all slave Read/Write bits are 0.
//  Stall and accept
//   - o_AVIn_WaitRequest = i_AVOut_WaitRequest[target]; it is 0 when the target is unmapped.
//   - A beat is accepted when (Read|Write) && !o_AVIn_WaitRequest.
//  FSM states: IDLE, BURST.
//   - IDLE: accepted beat with BurstCount>1: r_Sel<=target, r_Beats<=BurstCount-1, go to BURST.
//   - IDLE: accepted beat with BurstCount of 0 or 1: stay in IDLE.
//   - BURST: each accepted beat decrements r_Beats.
//   - BURST: the accept that moves r_Beats from 1 to 0 returns to IDLE in the same edge.
//   - A new master command is decoded only in IDLE.
//  Read return
//   - Slaves present read data the cycle after an accepted read (fixed latency 1).
//   - r_RdSel <= target on every accepted read, otherwise r_RdSel <= NUM_SLAVES.
//   - o_AVIn_ReadData = i_AVOut_ReadData[32*r_RdSel +: 32], or 0 when r_RdSel == NUM_SLAVES.
//   - Back-to-back reads to different slaves each return from the correct slave.
//  Unmapped access
//   - Accepted with zero wait; reads return 0; writes are dropped.
//   - Every unmapped beat increments o_ErrCount, saturating at 16'hFFFF.
//   - o_ErrAddr latches Addr on an unmapped IDLE-state accept.
//   - An unmapped burst is locked like a mapped one (r_Sel = unmapped) for all of its beats.
//  Simultaneous events
//   - Read and Write asserted together: treated as Write; Read is not forwarded.
//  Reset (also mid-burst)
//   - FSM <= IDLE, r_Beats <= 0, r_RdSel <= NUM_SLAVES, o_ErrCount <= 0, o_ErrAddr <= 0.
//   - While i_Reset=1: o_AVIn_WaitRequest=1, all slave Read/Write=0, o_AVIn_ReadData=0.
// TESTING
//  1. Write Addr=30'h0000_0010 (slave 0), slave 0 wait=0 -> o_AVOut_Write=2'b01, o_AVOut_Write[1]=0.
//     Beat accepted in 1 cycle.
//  2. Read to slave 1 with wait held 3 cycles -> o_AVIn_WaitRequest=1 for 3 cycles.
//     Cycle after accept: ReadData = slave1 data (32'hCAFE_F00D).
//  3. Read burst BurstCount=4 starting at slave 0; master Addr changes to slave 1 on beat 2
//     -> all 4 beats go to slave 0; FSM returns to IDLE after beat 4.
//  4. NUM_SLAVES=3, 2-bit field: read with idx=3 -> no slave Read; wait=0; next-cycle ReadData=0.
//     Also: o_ErrCount=1, o_ErrAddr=that address.
//  5. Back-to-back reads slave0 then slave1, one per cycle
//     -> ReadData sequence = slave0 data, then slave1 data, with no bubble.
//  6. Assert i_Reset during beat 2 of an 8-beat burst -> FSM IDLE, WaitRequest=1 while in reset.
//     First read after reset decodes its address afresh.

Source files
------------

// File: rtl/avalon_addr_decoder.sv
// Avalon-MM 1-to-N address decoder: routes one master port to NUM_SLAVES slaves by an
// address field, locks the slave for bursts and terminates unmapped accesses locally.
module avalon_addr_decoder #(
   parameter int unsigned NUM_SLAVES = 2,
   parameter int unsigned SEL_MSB    = 29,
   parameter int unsigned SEL_LSB    = 28
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset,
   input  logic [29:0]              i_AVIn_Addr,
   input  logic [3:0]               i_AVIn_ByteEn,
   input  logic                     i_AVIn_Read,
   output logic [31:0]              o_AVIn_ReadData,
   input  logic                     i_AVIn_Write,
   input  logic [31:0]              i_AVIn_WriteData,
   output logic                     o_AVIn_WaitRequest,
   input  logic [7:0]               i_AVIn_BurstCount,
   output logic [30*NUM_SLAVES-1:0] o_AVOut_Addr,
   output logic [4*NUM_SLAVES-1:0]  o_AVOut_ByteEn,
   output logic [NUM_SLAVES-1:0]    o_AVOut_Read,
   input  logic [32*NUM_SLAVES-1:0] i_AVOut_ReadData,
   output logic [NUM_SLAVES-1:0]    o_AVOut_Write,
   output logic [32*NUM_SLAVES-1:0] o_AVOut_WriteData,
   input  logic [NUM_SLAVES-1:0]    i_AVOut_WaitRequest,
   output logic [8*NUM_SLAVES-1:0]  o_AVOut_BurstCount,
   output logic [15:0]              o_ErrCount,
   output logic [29:0]              o_ErrAddr
);

   localparam int unsigned SW = SEL_MSB - SEL_LSB + 1;
   localparam int unsigned RW = $clog2(NUM_SLAVES + 1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t        r_State, w_NextState;
   logic [SW-1:0] r_Sel, w_Idx, w_Tgt;
   logic [7:0]    r_Beats, w_Bc;
   logic [RW-1:0] r_RdSel;
   logic          w_Mapped, w_Wr, w_Rd, w_Wait, w_Accept;

   assign o_AVOut_Addr       = {NUM_SLAVES{i_AVIn_Addr}};
   assign o_AVOut_ByteEn     = {NUM_SLAVES{i_AVIn_ByteEn}};
   assign o_AVOut_WriteData  = {NUM_SLAVES{i_AVIn_WriteData}};
   assign o_AVOut_BurstCount = {NUM_SLAVES{i_AVIn_BurstCount}};

   // During a burst the locked selection wins over whatever the address now says
   assign w_Idx    = i_AVIn_Addr[SEL_MSB:SEL_LSB];
   assign w_Tgt    = (r_State == S_IDLE) ? w_Idx : r_Sel;
   assign w_Mapped = 32'(w_Tgt) < NUM_SLAVES;
   assign w_Wr     = i_AVIn_Write;
   assign w_Rd     = i_AVIn_Read & ~i_AVIn_Write;
   assign w_Bc     = (i_AVIn_BurstCount == '0) ? 8'd1 : i_AVIn_BurstCount;
   assign w_Accept = (w_Rd | w_Wr) & ~w_Wait;

   assign o_AVIn_WaitRequest = w_Wait;

   always_comb begin
      o_AVOut_Read  = '0;
      o_AVOut_Write = '0;
      w_Wait        = 1'b0;
      for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
         if (w_Mapped && (32'(w_Tgt) == s)) begin
            w_Wait           = i_AVOut_WaitRequest[s];
            o_AVOut_Read[s]  = w_Rd;
            o_AVOut_Write[s] = w_Wr;
         end
      end
      if (i_Reset) begin
         o_AVOut_Read  = '0;
         o_AVOut_Write = '0;
         w_Wait        = 1'b1;
      end
   end

   always_comb begin
      o_AVIn_ReadData = '0;
      for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
         if (32'(r_RdSel) == s) o_AVIn_ReadData = i_AVOut_ReadData[32*s +: 32];
      end
      if (i_Reset) o_AVIn_ReadData = '0;
   end

   always_comb begin
      w_NextState = r_State;
      unique case (r_State)
         S_IDLE:  if (w_Accept && (w_Bc > 8'd1))     w_NextState = S_BURST;
         S_BURST: if (w_Accept && (r_Beats == 8'd1)) w_NextState = S_IDLE;
         default: w_NextState = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_State    <= S_IDLE;
         r_Sel      <= '0;
         r_Beats    <= '0;
         r_RdSel    <= RW'(NUM_SLAVES);
         o_ErrCount <= '0;
         o_ErrAddr  <= '0;
      end else begin
         r_State <= w_NextState;
         if (w_Accept) begin
            if (r_State == S_IDLE) begin
               if (w_Bc > 8'd1) begin
                  r_Sel   <= w_Tgt;
                  r_Beats <= w_Bc - 8'd1;
               end
            end else begin
               r_Beats <= r_Beats - 8'd1;
            end
         end
         // Unmapped reads park the return select on the "no slave" code so they read as 0
         r_RdSel <= (w_Accept && w_Rd && w_Mapped) ? RW'(w_Tgt) : RW'(NUM_SLAVES);
         if (w_Accept && !w_Mapped) begin
            if (o_ErrCount != '1) o_ErrCount <= o_ErrCount + 16'd1;
            if (r_State == S_IDLE) o_ErrAddr <= i_AVIn_Addr;
         end
      end
   end

endmodule

// File: tb/tb_avalon_addr_decoder.sv
// Scoreboard bench for avalon_addr_decoder with three slaves and a 2-bit select field.
module tb_avalon_addr_decoder;

   localparam int unsigned NS = 3;
   localparam logic [31:0] D0 = 32'h1234_5678;
   localparam logic [31:0] D1 = 32'hCAFE_F00D;
   localparam logic [31:0] D2 = 32'h5A5A_A5A5;

   logic            clk = 1'b0;
   logic            rst;
   logic [29:0]     addr;
   logic [3:0]      be;
   logic            rd, wr;
   logic [31:0]     wdata, rdata;
   logic            waitreq;
   logic [7:0]      bc;
   logic [30*NS-1:0] s_addr;
   logic [4*NS-1:0]  s_be;
   logic [NS-1:0]    s_rd, s_wr, s_wait;
   logic [32*NS-1:0] s_rdata, s_wdata;
   logic [8*NS-1:0]  s_bc;
   logic [15:0]      errcnt;
   logic [29:0]      erraddr;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   always #5 clk = ~clk;
   assign s_rdata = {D2, D1, D0};

   avalon_addr_decoder #(.NUM_SLAVES(NS), .SEL_MSB(29), .SEL_LSB(28)) dut (
      .i_Clk(clk), .i_Reset(rst),
      .i_AVIn_Addr(addr), .i_AVIn_ByteEn(be), .i_AVIn_Read(rd),
      .o_AVIn_ReadData(rdata), .i_AVIn_Write(wr), .i_AVIn_WriteData(wdata),
      .o_AVIn_WaitRequest(waitreq), .i_AVIn_BurstCount(bc),
      .o_AVOut_Addr(s_addr), .o_AVOut_ByteEn(s_be), .o_AVOut_Read(s_rd),
      .i_AVOut_ReadData(s_rdata), .o_AVOut_Write(s_wr), .o_AVOut_WriteData(s_wdata),
      .i_AVOut_WaitRequest(s_wait), .o_AVOut_BurstCount(s_bc),
      .o_ErrCount(errcnt), .o_ErrAddr(erraddr)
   );

   function automatic logic [31:0] sdata(input int s);
      case (s)
         0:       sdata = D0;
         1:       sdata = D1;
         default: sdata = D2;
      endcase
   endfunction

   task automatic bus(input logic [29:0] a, input logic r, input logic w, input logic [7:0] b);
      addr = a; rd = r; wr = w; bc = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_wait = '0; be = 4'hF; wdata = '0;
      bus(30'h0, 1'b1, 1'b0, 8'd1);
      tick();
      n_vec++; if (waitreq !== 1'b1) begin n_err++; $display("FAIL rst_wait: got %b exp 1", waitreq); end
      n_vec++; if (s_rd !== 3'b000) begin n_err++; $display("FAIL rst_rd: got %b exp 000", s_rd); end
      n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h exp 0", rdata); end
      tick();
      n_vec++; if (errcnt !== 16'h0) begin n_err++; $display("FAIL rst_errcnt: got %h exp 0", errcnt); end
      n_vec++; if (erraddr !== 30'h0) begin n_err++; $display("FAIL rst_erraddr: got %h exp 0", erraddr); end
      rst = 1'b0;
      bus(30'h0, 1'b0, 1'b0, 8'd1);
      #1;
      n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_idle_rdata: got %h exp 0", rdata); end
   endtask

   task automatic test_write();
      wdata = 32'hDEAD_BEEF;
      bus(30'h0000_0010, 1'b0, 1'b1, 8'd1);
      #1;
      n_vec++; if (s_wr !== 3'b001) begin n_err++; $display("FAIL wr_sel: got %b exp 001", s_wr); end
      n_vec++; if (waitreq !== 1'b0) begin n_err++; $display("FAIL wr_wait: got %b exp 0", waitreq); end
      n_vec++; if (s_wdata[63:32] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_bcast_data: got %h exp deadbeef", s_wdata[63:32]); end
      n_vec++; if (s_addr[89:60] !== 30'h0000_0010) begin n_err++; $display("FAIL wr_bcast_addr: got %h exp 10", s_addr[89:60]); end
      tick();
      bus(30'h0, 1'b0, 1'b0, 8'd1);
   endtask

   task automatic test_read_wait();
      s_wait = 3'b010;
      bus(30'h1000_0020, 1'b1, 1'b0, 8'd1);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++; if (waitreq !== 1'b1) begin n_err++; $display("FAIL rdw_wait%0d: got %b exp 1", c, waitreq); end
         n_vec++; if (s_rd !== 3'b010) begin n_err++; $display("FAIL rdw_rd%0d: got %b exp 010", c, s_rd); end
         n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rdw_rdata%0d: got %h exp 0", c, rdata); end
         tick();
      end
      s_wait = 3'b000;
      #1;
      n_vec++; if (waitreq !== 1'b0) begin n_err++; $display("FAIL rdw_release: got %b exp 0", waitreq); end
      exp_q.push_back(D1);
      tick();
      bus(30'h0, 1'b0, 1'b0, 8'd1);
      #1;
      e = exp_q.pop_front();
      n_vec++; if (rdata !== e) begin n_err++; $display("FAIL rdw_data: got %h exp %h", rdata, e); end
   endtask

   task automatic test_burst();
      bus(30'h0000_0100, 1'b1, 1'b0, 8'd4);
      #1;
      n_vec++; if (s_rd !== 3'b001) begin n_err++; $display("FAIL bst_beat1: got %b exp 001", s_rd); end
      exp_q.push_back(D0);
      tick();
      for (int b = 2; b <= 4; b++) begin
         bus(30'h1000_0100, 1'b1, 1'b0, 8'd4);
         #1;
         n_vec++; if (s_rd !== 3'b001) begin n_err++; $display("FAIL bst_beat%0d: got %b exp 001", b, s_rd); end
         e = exp_q.pop_front();
         n_vec++; if (rdata !== e) begin n_err++; $display("FAIL bst_data%0d: got %h exp %h", b - 1, rdata, e); end
         exp_q.push_back(D0);
         tick();
      end
      bus(30'h1000_0100, 1'b1, 1'b0, 8'd1);
      #1;
      n_vec++; if (s_rd !== 3'b010) begin n_err++; $display("FAIL bst_idle_decode: got %b exp 010", s_rd); end
      e = exp_q.pop_front();
      n_vec++; if (rdata !== e) begin n_err++; $display("FAIL bst_data4: got %h exp %h", rdata, e); end
      exp_q.push_back(D1);
      tick();
      bus(30'h0, 1'b0, 1'b0, 8'd1);
      #1;
      e = exp_q.pop_front();
      n_vec++; if (rdata !== e) begin n_err++; $display("FAIL bst_after: got %h exp %h", rdata, e); end
   endtask

   task automatic test_unmapped();
      bus(30'h3000_0044, 1'b1, 1'b0, 8'd1);
      #1;
      n_vec++; if ((s_rd | s_wr) !== 3'b000) begin n_err++; $display("FAIL um_rdwr: got %b exp 000", s_rd | s_wr); end
      n_vec++; if (waitreq !== 1'b0) begin n_err++; $display("FAIL um_wait: got %b exp 0", waitreq); end
      exp_q.push_back(32'h0);
      tick();
      bus(30'h0, 1'b0, 1'b0, 8'd1);
      #1;
      e = exp_q.pop_front();
      n_vec++; if (rdata !== e) begin n_err++; $display("FAIL um_rdata: got %h exp %h", rdata, e); end
      n_vec++; if (errcnt !== 16'd1) begin n_err++; $display("FAIL um_errcnt1: got %0d exp 1", errcnt); end
      n_vec++; if (erraddr !== 30'h3000_0044) begin n_err++; $display("FAIL um_erraddr1: got %h exp 30000044", erraddr); end
      s_wait = 3'b111;
      bus(30'h3000_0080, 1'b0, 1'b1, 8'd2);
      #1;
      n_vec++; if (waitreq !== 1'b0 || s_wr !== 3'b000) begin n_err++; $display("FAIL um_bst1: got wait=%b wr=%b exp 0/000", waitreq, s_wr); end
      tick();
      bus(30'h0000_0080, 1'b0, 1'b1, 8'd2);
      #1;
      n_vec++; if (waitreq !== 1'b0 || s_wr !== 3'b000) begin n_err++; $display("FAIL um_bst2_locked: got wait=%b wr=%b exp 0/000", waitreq, s_wr); end
      tick();
      bus(30'h0, 1'b0, 1'b0, 8'd1);
      s_wait = 3'b000;
      #1;
      n_vec++; if (errcnt !== 16'd3) begin n_err++; $display("FAIL um_errcnt3: got %0d exp 3", errcnt); end
      n_vec++; if (erraddr !== 30'h3000_0080) begin n_err++; $display("FAIL um_erraddr2: got %h exp 30000080", erraddr); end
   endtask

   task automatic test_back_to_back();
      logic [29:0] ta[4];
      int          ts[4];
      logic [7:0]  tbc[4];
      ta  = '{30'h0000_0004, 30'h1000_0008, 30'h2000_000C, 30'h0000_0010};
      ts  = '{0, 1, 2, 0};
      tbc = '{8'd1, 8'd0, 8'd1, 8'd1};
      for (int i = 0; i < 4; i++) begin
         bus(ta[i], 1'b1, 1'b0, tbc[i]);
         #1;
         n_vec++; if (s_rd !== 3'(1 << ts[i])) begin n_err++; $display("FAIL b2b_sel%0d: got %b exp %b", i, s_rd, 3'(1 << ts[i])); end
         if (i > 0) begin
            e = exp_q.pop_front();
            n_vec++; if (rdata !== e) begin n_err++; $display("FAIL b2b_data%0d: got %h exp %h", i - 1, rdata, e); end
         end
         exp_q.push_back(sdata(ts[i]));
         tick();
      end
      bus(30'h0, 1'b0, 1'b0, 8'd1);
      #1;
      e = exp_q.pop_front();
      n_vec++; if (rdata !== e) begin n_err++; $display("FAIL b2b_data3: got %h exp %h", rdata, e); end
   endtask

   task automatic test_rw_both();
      bus(30'h1000_0040, 1'b1, 1'b1, 8'd1);
      #1;
      n_vec++; if (s_wr !== 3'b010) begin n_err++; $display("FAIL rw_wr: got %b exp 010", s_wr); end
      n_vec++; if (s_rd !== 3'b000) begin n_err++; $display("FAIL rw_rd: got %b exp 000", s_rd); end
      tick();
      bus(30'h0, 1'b0, 1'b0, 8'd1);
      #1;
      n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rw_rdata: got %h exp 0", rdata); end
   endtask

   task automatic test_reset_midburst();
      bus(30'h0000_0200, 1'b1, 1'b0, 8'd8);
      #1;
      n_vec++; if (s_rd !== 3'b001) begin n_err++; $display("FAIL mrst_beat1: got %b exp 001", s_rd); end
      tick();
      bus(30'h1000_0200, 1'b1, 1'b0, 8'd8);
      rst = 1'b1;
      #1;
      n_vec++; if (waitreq !== 1'b1) begin n_err++; $display("FAIL mrst_wait: got %b exp 1", waitreq); end
      n_vec++; if ((s_rd | s_wr) !== 3'b000) begin n_err++; $display("FAIL mrst_rdwr: got %b exp 000", s_rd | s_wr); end
      n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL mrst_rdata: got %h exp 0", rdata); end
      tick();
      rst = 1'b0;
      bus(30'h1000_0200, 1'b1, 1'b0, 8'd1);
      #1;
      n_vec++; if (s_rd !== 3'b010 || waitreq !== 1'b0) begin n_err++; $display("FAIL mrst_redecode: got rd=%b wait=%b exp 010/0", s_rd, waitreq); end
      n_vec++; if (errcnt !== 16'd0) begin n_err++; $display("FAIL mrst_errcnt: got %0d exp 0", errcnt); end
      exp_q.push_back(D1);
      tick();
      bus(30'h0, 1'b0, 1'b0, 8'd1);
      #1;
      e = exp_q.pop_front();
      n_vec++; if (rdata !== e) begin n_err++; $display("FAIL mrst_data: got %h exp %h", rdata, e); end
   endtask

   initial begin
      test_reset();
      tick();
      test_write();
      tick();
      test_read_wait();
      tick();
      test_burst();
      tick();
      test_unmapped();
      tick();
      test_back_to_back();
      tick();
      test_rw_both();
      tick();
      test_reset_midburst();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
